// File: rtl/alu_seq.sv
// Handshaked signed ALU: single-cycle logic/arith ops, iterative divide/modulo/power.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for ops 3-6 (not data dependent).
// Backpressure: result held in HOLD until out_ready; a new command is taken on the consuming edge.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] signal_A,
    input  logic [WIDTH-1:0] signal_B,
    input  logic [3:0]       signal_S_op_select,
    input  logic             signal_in_valid,
    output logic             signal_in_ready,
    output logic [WIDTH-1:0] signal_Y,
    output logic             signal_Z,
    output logic             signal_N,
    output logic             signal_E,
    output logic             signal_out_valid,
    input  logic             signal_out_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam int               CW       = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] WVAL     = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] dvs, rem, quo;
    logic [WIDTH-1:0] acc, base, expn;
    logic [WIDTH-1:0] y_q;
    logic             z_q, n_q, e_q, ov_q;

    logic             accept, is_iter, shift_ok;
    logic [WIDTH-1:0] sc_y, abs_a, abs_b;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nx, quo_nx, acc_nx;
    logic [WIDTH-1:0] quo_s, rem_s, mod_s, pow_y, fin_y;
    logic             fin_e, sa, sb;

    assign signal_in_ready  = (state == IDLE) || (state == HOLD && signal_out_ready);
    assign accept           = signal_in_valid && signal_in_ready;
    assign is_iter          = (signal_S_op_select >= 4'd3) && (signal_S_op_select <= 4'd6);
    assign abs_a            = signal_A[WIDTH-1] ? -signal_A : signal_A;
    assign abs_b            = signal_B[WIDTH-1] ? -signal_B : signal_B;
    assign shift_ok         = !signal_B[WIDTH-1] && (signal_B < WVAL);

    assign signal_Y         = y_q;
    assign signal_Z         = z_q;
    assign signal_N         = n_q;
    assign signal_E         = e_q;
    assign signal_out_valid = ov_q;

    always_comb begin
        sc_y = '0;
        case (signal_S_op_select)
            4'd0:    sc_y = signal_A + signal_B;
            4'd1:    sc_y = signal_A - signal_B;
            4'd2:    sc_y = signal_A * signal_B;
            4'd7:    sc_y = -signal_A;
            4'd8:    sc_y = signal_A | signal_B;
            4'd9:    sc_y = signal_A & signal_B;
            4'd10:   sc_y = signal_A ^ signal_B;
            4'd11:   sc_y = {{(WIDTH-1){1'b0}}, ($signed(signal_A) > $signed(signal_B))};
            4'd12:   sc_y = {{(WIDTH-1){1'b0}}, (signal_A == signal_B)};
            4'd13:   sc_y = shift_ok ? (signal_A << signal_B) : '0;
            4'd14:   sc_y = shift_ok ? (signal_A >> signal_B) : '0;
            4'd15:   sc_y = signal_A;
            default: sc_y = '0;
        endcase
    end

    // One restoring-division step and one square-and-multiply step per ITER cycle.
    always_comb begin
        trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
        if (!trial[WIDTH]) begin
            rem_nx = trial[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo_nx = {quo[WIDTH-2:0], 1'b0};
        end
        acc_nx = expn[0] ? acc * base : acc;
    end

    // Sign correction is folded into the last iteration so ITER lasts exactly WIDTH cycles.
    always_comb begin
        sa    = a_q[WIDTH-1];
        sb    = b_q[WIDTH-1];
        quo_s = (sa ^ sb) ? -quo_nx : quo_nx;
        rem_s = sa ? -rem_nx : rem_nx;
        mod_s = (rem_nx != '0 && sa != sb) ? rem_s + b_q : rem_s;
        if (!sb) begin
            pow_y = acc_nx;
        end else if (a_q == ONE) begin
            pow_y = ONE;
        end else if (a_q == '1) begin
            pow_y = b_q[0] ? '1 : ONE;
        end else begin
            pow_y = '0;
        end
        fin_y = '0;
        fin_e = 1'b0;
        case (op_q)
            4'd3, 4'd4, 4'd5: begin
                if (b_q == '0) begin
                    fin_e = 1'b1;
                end else if (op_q == 4'd3) begin
                    fin_y = quo_s;
                end else if (op_q == 4'd4) begin
                    fin_y = rem_s;
                end else begin
                    fin_y = mod_s;
                end
            end
            default: fin_y = pow_y;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            dvs   <= '0;
            rem   <= '0;
            quo   <= '0;
            acc   <= '0;
            base  <= '0;
            expn  <= '0;
            y_q   <= '0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            e_q   <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (state == HOLD && signal_out_ready) begin
                        ov_q  <= 1'b0;
                        state <= IDLE;
                    end
                    if (accept) begin
                        op_q <= signal_S_op_select;
                        a_q  <= signal_A;
                        b_q  <= signal_B;
                        if (is_iter) begin
                            dvs   <= abs_b;
                            quo   <= abs_a;
                            rem   <= '0;
                            acc   <= ONE;
                            base  <= signal_A;
                            expn  <= signal_B;
                            cnt   <= CNT_INIT;
                            state <= ITER;
                        end else begin
                            y_q   <= sc_y;
                            z_q   <= (sc_y == '0);
                            n_q   <= sc_y[WIDTH-1];
                            e_q   <= 1'b0;
                            ov_q  <= 1'b1;
                            state <= HOLD;
                        end
                    end
                end
                ITER: begin
                    rem  <= rem_nx;
                    quo  <= quo_nx;
                    acc  <= acc_nx;
                    base <= base * base;
                    expn <= expn >> 1;
                    if (cnt == CW'(1)) begin
                        y_q   <= fin_y;
                        z_q   <= (fin_y == '0);
                        n_q   <= fin_y[WIDTH-1];
                        e_q   <= fin_e;
                        ov_q  <= 1'b1;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Handshaked, parametrised-width sequential ALU; successor to the combinational 16-op ALU. Single-cycle ops complete in one clock; divide, both modulo forms and power run on iterative datapaths with fixed, width-dependent latency. Sits between an operand/opcode source and a result consumer on valid/ready interfaces, with zero, negative and error flags on every result.

## Interface
- WIDTH, 32, operand/result width in bits, two's complement; legal range 4..64.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- signal_A  input  WIDTH  signed operand A.
- signal_B  input  WIDTH  signed operand B.
- signal_S_op_select  input  4  opcode, sampled with the operands.
- signal_in_valid  input  1  operands/opcode valid.
- signal_in_ready  output  1  block accepts a command this cycle.
- signal_Y  output  WIDTH  result, registered.
- signal_Z  output  1  result equals zero.
- signal_N  output  1  result MSB.
- signal_E  output  1  error: divide/modulo by zero.
- signal_out_valid  output  1  result and flags valid.
- signal_out_ready  input  1  consumer takes the result.

## Operation
- Opcodes (A, B signed; all results truncated to WIDTH bits): 0 A+B; 1 A-B; 2 A*B (low WIDTH bits); 3 A/B truncating toward zero; 4 remainder, sign follows A; 5 modulo, sign follows B (zero result if remainder zero); 6 A**B; 7 -A; 8 A|B; 9 A&B; 10 A^B; 11 signed A>B as 0/1; 12 A==B as 0/1; 13 A<<B; 14 logical A>>B; 15 A.
- Shifts: B negative or B>=WIDTH gives 0.
- Divide/modulo: restoring division on magnitudes, one quotient bit per cycle, sign correction in the final cycle. B=0: Y=0, E=1. Most-negative/-1: Y=most-negative (wrap), E=0.
- Power: right-to-left square-and-multiply over all WIDTH bits of B, no early exit. B<0: Y=1 if A=1; Y=(B odd ? -1 : 1) if A=-1; else 0. A**0=1, including 0**0.
- E is 0 for every opcode other than 3/4/5.
- States: IDLE (accepting); ITER (divide or power, counter runs WIDTH cycles); HOLD (result valid, awaiting out_ready).
- IDLE: in_valid and in_ready accepts; ops 0-2, 7-15 go straight to HOLD with result; ops 3-6 load the iterator and go to ITER.
- ITER: counter decrements each cycle; on the last iteration plus correction cycle, registers the result and goes to HOLD. Inputs ignored; in_ready=0.
- HOLD: out_valid=1; Y/Z/N/E stable until out_valid && out_ready. On that edge, a simultaneously accepted command is taken (next state per its opcode); otherwise back to IDLE.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). Combinational, does not depend on in_valid.

## Timing
- Reset (async assert, synchronous deassert by the source): state IDLE, Y=0, Z=0, N=0, E=0, out_valid=0; in_ready=1 on the first cycle after release.
- Single-cycle op accepted at edge k: out_valid=1 after edge k+1 (one cycle latency); with out_ready held high, throughput one per clock.
- Ops 3-6 accepted at edge k: out_valid=1 after edge k+WIDTH+1; not data-dependent.
- Result bus changes only on the edge that sets out_valid.
- Reset asserted mid-ITER or HOLD: command and result dropped, outputs return to reset values immediately.
- Opcode/operands changing while in_ready=0 or in_valid=0 have no effect.

## Test plan
- WIDTH=32, op0, A=0x7FFFFFFF, B=1 -> Y=0x80000000, N=1, Z=0, E=0, out_valid one cycle after accept.
- op3 A=-7 B=2 -> Y=-3; op4 -> Y=-1; op5 -> Y=1; each out_valid exactly 33 cycles after accept; op3 A=5 B=0 -> Y=0, Z=1, E=1.
- op6 A=3 B=4 -> Y=81 after 33 cycles; A=-1 B=-3 -> Y=-1; A=2 B=-1 -> Y=0, Z=1.
- Back-to-back op0/op8/op13 (B=40 -> Y=0) with out_ready=1 -> one result per clock, in order; then out_ready=0 for 5 cycles -> Y stable, in_ready=0, no commands lost.
- Assert rst_n=0 at cycle 10 of a divide -> out_valid=0, Y=0 immediately; after release a fresh op1 A=3 B=5 -> Y=-2 one cycle after accept.
- WIDTH=8 rebuild: op2 A=16 B=16 -> Y=0, Z=1; op3 A=-128 B=-1 -> Y=-128, E=0, latency 9 cycles.
